// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
// Holds requester/select widths, hold-counter width, FSM encoding and a one-hot helper.
package mux8_arb_pkg;

  localparam int NUM_REQ    = 8;
  localparam int SEL_W      = 3;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// rr_pick8: combinational round-robin picker; finds the first set request at or
// above 'start' (wrapping 7->0), optionally ignoring one excluded index.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  input  logic               exclude_en,
  input  logic [SEL_W-1:0]   exclude_idx,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   offset;

  // rot[k] is the candidate k positions past 'start', so bit 0 has top priority.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = req[gi] & ~(exclude_en && (exclude_idx == SEL_W'(gi)));
      assign rot[gi]  = cand[start + SEL_W'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = SEL_W'(k);
      end
    end
  end

  assign found = |rot;
  assign idx   = start + offset;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of the shared 8:1 single-bit mux.
// Optional hold limit per owner is compiled in with MUX8_ARB_HOLD_LIMIT_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               owner_changed
);

  arb_state_t         state_reg, state_next;
  logic [SEL_W-1:0]   last_owner_reg, last_owner_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               sel_valid_reg, sel_valid_next;
  logic               owner_changed_reg, owner_changed_next;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               take_grant;

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
    end
  endgenerate

`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
  logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
`endif

  // While owned, the current owner is excluded so it is always searched last.
  rr_pick8 u_pick (
    .req         (req),
    .start       (last_owner_reg + SEL_W'(1)),
    .exclude_en  (state_reg == OWN),
    .exclude_idx (last_owner_reg),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  always_comb begin
    state_next         = state_reg;
    last_owner_next    = last_owner_reg;
    grant_next         = grant_reg;
    sel_next           = sel_reg;
    sel_valid_next     = sel_valid_reg;
    owner_changed_next = 1'b0;
    take_grant         = 1'b0;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
    hold_cnt_next      = hold_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        take_grant = pick_found;
      end
      OWN: begin
        if (!req[last_owner_reg]) begin
          if (pick_found) begin
            take_grant = 1'b1;
          end else begin
            grant_next     = '0;
            sel_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
`ifdef MUX8_ARB_HOLD_LIMIT_EN
        else if (hold_cnt_reg == HOLD_LAST) begin
          if (pick_found) begin
            take_grant = 1'b1;
          end else begin
            hold_cnt_next = '0;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
        end
`endif
      end
    endcase

    if (take_grant) begin
      grant_next         = onehot(pick_idx);
      sel_next           = pick_idx;
      sel_valid_next     = 1'b1;
      owner_changed_next = 1'b1;
      last_owner_next    = pick_idx;
      state_next         = OWN;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
      hold_cnt_next      = '0;
`endif
    end
  end

  // last_owner resets to 7 so the first search starts at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      last_owner_reg    <= SEL_W'(NUM_REQ - 1);
      grant_reg         <= '0;
      sel_reg           <= '0;
      sel_valid_reg     <= 1'b0;
      owner_changed_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      last_owner_reg    <= last_owner_next;
      grant_reg         <= grant_next;
      sel_reg           <= sel_next;
      sel_valid_reg     <= sel_valid_next;
      owner_changed_reg <= owner_changed_next;
    end
  end

`ifdef MUX8_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`endif

  assign grant         = grant_reg;
  assign sel           = sel_reg;
  assign sel_valid     = sel_valid_reg;
  assign owner_changed = owner_changed_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: stimulus queues expected outputs per clock
// edge (or asynchronous reset edge); a monitor pops and compares them.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic       owner_changed;

  typedef struct {
    string      name;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       oc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .grant         (grant),
    .sel           (sel),
    .sel_valid     (sel_valid),
    .owner_changed (owner_changed)
  );

  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [7:0] g, input logic [2:0] s,
                      input logic v, input logic oc);
    exp_t e;
    e.name  = nm;
    e.req   = req;
    e.grant = g;
    e.sel   = s;
    e.valid = v;
    e.oc    = oc;
    exp_q.push_back(e);
  endtask

  // Drive one cycle: inputs at negedge, expectation is the state after the next posedge.
  task automatic cyc(input string nm, input logic r_rst, input logic [7:0] r,
                     input logic [7:0] g, input logic [2:0] s, input logic v, input logic oc);
    @(negedge clk);
    rst = r_rst;
    req = r;
    push(nm, g, s, v, oc);
    @(posedge clk);
  endtask

  // Monitor: checks on every clock edge and on asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        total += 4;
        if (grant !== e.grant) begin
          bad++;
          $display("FAIL %s[%0d] grant got=%h want=%h", e.name, txn, grant, e.grant);
        end
        if (sel !== e.sel) begin
          bad++;
          $display("FAIL %s[%0d] sel got=%0d want=%0d", e.name, txn, sel, e.sel);
        end
        if (sel_valid !== e.valid) begin
          bad++;
          $display("FAIL %s[%0d] sel_valid got=%b want=%b", e.name, txn, sel_valid, e.valid);
        end
        if (owner_changed !== e.oc) begin
          bad++;
          $display("FAIL %s[%0d] owner_changed got=%b want=%b", e.name, txn, owner_changed, e.oc);
        end
        $display("txn %0d %s: req=%h grant=%h sel=%0d valid=%b oc=%b",
                 txn, e.name, e.req, grant, sel, sel_valid, owner_changed);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while rst is held.
    push("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    cyc("reset_hold", 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc("idle_noreq", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    cyc("first_grant", 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
    cyc("hold0", 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);

    // Full rotation: each owner drops its bit for one cycle.
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] r;
      logic [7:0] g;
      logic [2:0] s;
      r = ~(8'h01 << ((k - 1) % 8));
      s = 3'(k % 8);
      g = 8'h01 << s;
      cyc("rotate", 1'b0, r, g, s, 1'b1, 1'b1);
    end
    cyc("hold_ff", 1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);

    // Owner 5, non-owner request ignored, then wrap past 7 to 0.
    cyc("to5", 1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
    cyc("no_preempt", 1'b0, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0);
    cyc("wrap", 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);

    // Release to idle keeps sel; idle search resumes after last owner.
    cyc("to3", 1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
    cyc("release", 1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    cyc("idle", 1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    cyc("idle_wrap", 1'b0, 8'h09, 8'h01, 3'd0, 1'b1, 1'b1);
    cyc("rr_from0", 1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);

    // Asynchronous reset between edges while owner 3 holds.
    @(negedge clk);
    #2;
    push("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    cyc("rst_held", 1'b1, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc("after_rst", 1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
    cyc("release7", 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

    // Constant req=03: alternates every 4 cycles with the hold limit, else owner 0 keeps it.
    for (int k = 1; k <= 12; k++) begin
`ifdef MUX8_ARB_HOLD_LIMIT_EN
      if (((k - 1) / 4) % 2 == 1)
        cyc("hold_limit", 1'b0, 8'h03, 8'h02, 3'd1, 1'b1, ((k - 1) % 4) == 0);
      else
        cyc("hold_limit", 1'b0, 8'h03, 8'h01, 3'd0, 1'b1, ((k - 1) % 4) == 0);
`else
      cyc("hold_forever", 1'b0, 8'h03, 8'h01, 3'd0, 1'b1, k == 1);
`endif
    end
    for (int k = 0; k < 6; k++) begin
      cyc("sole_owner", 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    end

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's 8-to-1 single-bit mux between 8 requesters.
- Samples a request vector, grants exactly one requester, and drives the mux select lines (sel, MSB = sel[2]; mux input index = sel) plus a valid qualifier.
- Sits directly in front of the mux; downstream logic samples the mux output only while sel_valid=1.

Parameters:
- HOLD_MAX, 16, maximum consecutive grant cycles per owner (used only when MUX8_ARB_HOLD_LIMIT_EN is defined); legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  8  request vector; bit i requests mux input i
- grant  output  8  one-hot grant, registered
- sel  output  3  mux select = binary index of granted bit, registered
- sel_valid  output  1  1 when grant is non-zero (mux output meaningful)
- owner_changed  output  1  single-cycle pulse on the cycle a new owner's grant first appears

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high; all outputs are registered.
- Reset values: grant=8'h00, sel=3'd0, sel_valid=0, owner_changed=0, state=IDLE, last_owner pointer=3'd7 (so index 0 wins first), hold counter=0.
- States: IDLE (no owner), OWN (one owner holds grant).
- IDLE: if req==0, stay. Otherwise pick the first set bit searching upward from last_owner+1 mod 8 (wrap 7->0); next cycle grant/sel reflect it, sel_valid=1, owner_changed=1, go to OWN. Latency req->grant = 1 cycle.
- OWN: owner keeps grant while req[owner]=1. When req[owner]=0 on a clock edge:
  - other requesters pending -> pick next via round-robin starting at owner+1; new grant appears that same edge (no idle bubble), owner_changed=1.
  - none pending -> grant=0, sel_valid=0, sel holds last value, go to IDLE.
- last_owner updates to the new index on every grant.
- Requests of non-owners never preempt; changes to non-owner req bits while owned are ignored until release.
- Simultaneous release and new request on the owner's own bit in the same cycle: the owner is treated as released; its index is searched last (fairness).
- owner_changed is 0 whenever the owner is unchanged, including the first cycle after reset.
- Reset asserted mid-grant: outputs return to reset values immediately (asynchronous); no grant resumes until 1 cycle after rst deasserts and req is sampled.
- Invariants: grant is zero or one-hot; sel == index(grant) whenever sel_valid=1; sel_valid == |grant.

Optional Feature:
- Macro MUX8_ARB_HOLD_LIMIT_EN.
- Defined: 8-bit hold counter clears on every new grant and increments each OWN cycle. When it reaches HOLD_MAX-1 while req[owner]=1 and another requester is pending, a forced release occurs: the next round-robin owner is granted at the next edge with owner_changed=1. If no other requester is pending, the owner keeps its grant and the counter clears.
- Not defined: no counter; the owner holds the grant indefinitely while req[owner]=1.

Decomposition:
- Shared package mux8_arb_pkg: NUM_REQ=8, SEL_W=3, state encodings IDLE/OWN, HOLD_CNT_W=8.
- One sub-module, rr_pick8: combinational round-robin picker. Inputs: req[7:0], start[2:0], exclude_en, exclude_idx. Outputs: found, idx[2:0]. Instantiated once in the arbiter.
- The existing 8-to-1 mux is instantiated by the integrating level, not inside this block.

Test Plan:
- Reset then req=8'h01 -> one cycle later grant=8'h01, sel=0, sel_valid=1, owner_changed pulses once.
- req=8'hFF, each owner drops its req for one cycle after being granted -> grants rotate 0,1,...,7,0 with no idle cycles; sel tracks the index.
- Owner 5 holds, req=8'h21, then req[5] falls -> next edge grant=8'h01 (wrap past 7), sel=0.
- req drops to 0 while owned -> grant=0, sel_valid=0, sel retains last index, state IDLE.
- rst pulsed mid-grant (asynchronous, between edges) -> grant=0 immediately; after release with req=8'h80, grant=8'h80 one cycle later.
- With MUX8_ARB_HOLD_LIMIT_EN and HOLD_MAX=4: req=8'h03 held constant -> grant alternates every 4 cycles; with req=8'h01 only, grant stays 8'h01 indefinitely.
